// File: rtl/sft_l_sat_pipe_if.sv
// -----------------------------------------------------------------------------
// sft_l_sat_pipe_if
// Handshake bundle for the pipelined saturating left shifter.
//
// Signals:
//   in_valid   upstream beat valid
//   in_ready   shifter can take a beat this cycle
//   x          two's-complement input data
//   sel        left-shift amount, 0..63
//   out_valid  y/ovf hold a result
//   out_ready  downstream takes the result
//   y          shifted (optionally saturated) result
//   ovf        overflow flag for the beat on y
//
// Modports:
//   master  producer of x/sel and consumer of y/ovf (the surrounding logic)
//   slave   the shifter itself
// -----------------------------------------------------------------------------
interface sft_l_sat_pipe_if #(
   parameter int D_WIDTH   = 16,
   parameter int SEL_WIDTH = 6
);
   logic                 in_valid;
   logic                 in_ready;
   logic [D_WIDTH-1:0]   x;
   logic [SEL_WIDTH-1:0] sel;
   logic                 out_valid;
   logic                 out_ready;
   logic [D_WIDTH-1:0]   y;
   logic                 ovf;

   modport master (
      output in_valid, x, sel, out_ready,
      input  in_ready, out_valid, y, ovf
   );

   modport slave (
      input  in_valid, x, sel, out_ready,
      output in_ready, out_valid, y, ovf
   );
endinterface

// File: rtl/sft_l_sat_pipe.sv
// -----------------------------------------------------------------------------
// sft_l_sat_pipe
// Four-stage pipelined arithmetic left shifter for 16-bit two's-complement
// data. Each stage applies one binary-weighted shift (1, 2, 4, 8) and a sticky
// overflow bit follows the beat. Shift amounts of 16 or more clear the data in
// the last stage. Used to scale normalised values back up before write-back.
//
// Ports:
//   clk    clock, all state changes on the rising edge
//   rst_n  synchronous active-low reset
//   bus    sft_l_sat_pipe_if.slave: in_valid/in_ready/x/sel on the input
//          side, out_valid/out_ready/y/ovf on the output side
//
// Build option:
//   SFT_L_SAT_EN  when defined, an overflowing beat produces the signed
//                 extreme (0x8000 for negative input, 0x7FFF otherwise)
//                 instead of the wrapped shift result. ovf is the same either way.
// -----------------------------------------------------------------------------
module sft_l_sat_pipe #(
   parameter int D_WIDTH   = 16,
   parameter int SEL_WIDTH = 6
) (
   input logic             clk,
   input logic             rst_n,
   sft_l_sat_pipe_if.slave bus
);

`ifdef SFT_L_SAT_EN
   localparam bit SatEn = 1'b1;
`else
   localparam bit SatEn = 1'b0;
`endif

   typedef logic [D_WIDTH-1:0] data_t;

   // A shift by k is lossless only when the top k+1 bits are all equal;
   // mask selects exactly those bits.
   function automatic logic shiftOvf(input data_t d, input data_t mask);
      return !(((d & mask) == '0) || ((d & mask) == mask));
   endfunction

   logic adv;

   logic                 v1_q, v1_d, s1_q, s1_d, o1_q, o1_d;
   data_t                d1_q, d1_d;
   logic [SEL_WIDTH-2:0] sel1_q, sel1_d;

   logic                 v2_q, v2_d, s2_q, s2_d, o2_q, o2_d;
   data_t                d2_q, d2_d;
   logic [SEL_WIDTH-3:0] sel2_q, sel2_d;

   logic                 v3_q, v3_d, s3_q, s3_d, o3_q, o3_d;
   data_t                d3_q, d3_d;
   logic [SEL_WIDTH-4:0] sel3_q, sel3_d;

   logic                 v4_q, v4_d, o4_q, o4_d;
   data_t                y_q, y_d;

   data_t                shift4;
   logic                 ovf4;

   // The whole pipe moves together; it only stops when a finished beat is
   // waiting at the output and nobody takes it.
   always_comb begin
      adv = bus.out_ready | ~v4_q;
   end

   assign bus.in_ready  = adv;
   assign bus.out_valid = v4_q;
   assign bus.y         = y_q;
   assign bus.ovf       = o4_q;

   // Last stage: shift by 8, or flush to zero for shift amounts of 16 and up.
   // In the flush case any non-zero value is lost, which is exactly the
   // overflow condition. Saturation replaces the result here so y is registered.
   always_comb begin
      shift4 = sel3_q[0] ? {d3_q[D_WIDTH-9:0], 8'h00} : d3_q;
      ovf4   = o3_q | (sel3_q[0] & shiftOvf(d3_q, 16'hFF80));
      if (sel3_q[2:1] != 2'b00) begin
         shift4 = '0;
         ovf4   = o3_q | (d3_q != '0);
      end
   end

   // Next-state for every stage: hold while stalled, otherwise each stage
   // takes its upstream neighbour's value with one more shift level applied.
   always_comb begin
      v1_d = v1_q; d1_d = d1_q; sel1_d = sel1_q; s1_d = s1_q; o1_d = o1_q;
      v2_d = v2_q; d2_d = d2_q; sel2_d = sel2_q; s2_d = s2_q; o2_d = o2_q;
      v3_d = v3_q; d3_d = d3_q; sel3_d = sel3_q; s3_d = s3_q; o3_d = o3_q;
      v4_d = v4_q; y_d  = y_q;  o4_d   = o4_q;
      if (adv) begin
         v1_d   = bus.in_valid & adv;
         d1_d   = bus.sel[0] ? {bus.x[D_WIDTH-2:0], 1'b0} : bus.x;
         sel1_d = bus.sel[SEL_WIDTH-1:1];
         s1_d   = bus.x[D_WIDTH-1];
         o1_d   = bus.sel[0] & shiftOvf(bus.x, 16'hC000);

         v2_d   = v1_q;
         d2_d   = sel1_q[0] ? {d1_q[D_WIDTH-3:0], 2'b00} : d1_q;
         sel2_d = sel1_q[SEL_WIDTH-2:1];
         s2_d   = s1_q;
         o2_d   = o1_q | (sel1_q[0] & shiftOvf(d1_q, 16'hE000));

         v3_d   = v2_q;
         d3_d   = sel2_q[0] ? {d2_q[D_WIDTH-5:0], 4'h0} : d2_q;
         sel3_d = sel2_q[SEL_WIDTH-3:1];
         s3_d   = s2_q;
         o3_d   = o2_q | (sel2_q[0] & shiftOvf(d2_q, 16'hF800));

         v4_d   = v3_q;
         o4_d   = ovf4;
         y_d    = (SatEn && ovf4) ? (s3_q ? 16'h8000 : 16'h7FFF) : shift4;
      end
   end

   // Stage registers; reset discards every beat in flight.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         v1_q <= 1'b0; d1_q <= '0; sel1_q <= '0; s1_q <= 1'b0; o1_q <= 1'b0;
         v2_q <= 1'b0; d2_q <= '0; sel2_q <= '0; s2_q <= 1'b0; o2_q <= 1'b0;
         v3_q <= 1'b0; d3_q <= '0; sel3_q <= '0; s3_q <= 1'b0; o3_q <= 1'b0;
         v4_q <= 1'b0; y_q  <= '0; o4_q   <= 1'b0;
      end else begin
         v1_q <= v1_d; d1_q <= d1_d; sel1_q <= sel1_d; s1_q <= s1_d; o1_q <= o1_d;
         v2_q <= v2_d; d2_q <= d2_d; sel2_q <= sel2_d; s2_q <= s2_d; o2_q <= o2_d;
         v3_q <= v3_d; d3_q <= d3_d; sel3_q <= sel3_d; s3_q <= s3_d; o3_q <= o3_d;
         v4_q <= v4_d; y_q  <= y_d;  o4_q   <= o4_d;
      end
   end

endmodule

// File: tb/tb_sft_l_sat_pipe.sv
// -----------------------------------------------------------------------------
// tb_sft_l_sat_pipe
// Self-checking bench for sft_l_sat_pipe. A reference model computes each
// beat's result with wide integer arithmetic (x * 2^sel, range test, wrap or
// saturate); a negedge monitor compares every output beat against a queue of
// model results. Directed beats pin the model with literal values.
// Honours SFT_L_SAT_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_sft_l_sat_pipe;

`ifdef SFT_L_SAT_EN
   localparam bit SatEn = 1'b1;
`else
   localparam bit SatEn = 1'b0;
`endif

   logic clk = 1'b0;
   logic rstN;

   int checkCount  = 0;
   int passCount   = 0;
   int stallCycles = 0;

   logic [16:0] expQ[$];
   logic [15:0] gotQ[$];
   bit          collect = 1'b0;

   logic [16:0] monExp;
   logic        monRdy;
   logic [15:0] prevY;
   logic        prevOvf;
   bit          prevStall = 1'b0;

   sft_l_sat_pipe_if bus ();

   sft_l_sat_pipe dut (
      .clk   (clk),
      .rst_n (rstN),
      .bus   (bus)
   );

   // Free-running clock, period 10.
   always #5 clk = ~clk;

   // Reference: the exact product x*2^sel fits in 16 signed bits or it overflows.
   function automatic logic [16:0] modelBeat(input logic [15:0] xv, input logic [5:0] sv);
      logic signed [127:0] full;
      logic                o;
      logic [15:0]         r;
      full = {{112{xv[15]}}, xv};
      full = full <<< sv;
      o    = (full > 128'sd32767) || (full < -128'sd32768);
      r    = full[15:0];
      if (SatEn && o) r = xv[15] ? 16'h8000 : 16'h7FFF;
      return {o, r};
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checkCount++;
      if (act === exp) passCount++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Drive one beat and hold it until the shifter takes it (bounded).
   task automatic applyStimulus(input logic [15:0] xv, input logic [5:0] sv);
      bit acc;
      acc          = 1'b0;
      bus.in_valid = 1'b1;
      bus.x        = xv;
      bus.sel      = sv;
      for (int n = 0; n < 50 && !acc; n++) begin
         @(negedge clk);
         acc = (bus.in_ready === 1'b1) && (rstN === 1'b1);
         @(posedge clk);
         #1;
      end
      bus.in_valid = 1'b0;
      if (!acc) checkOutput("accept_timeout", 32'd0, 32'd1);
   endtask

   // Single beat with literal expectations and a latency measurement.
   task automatic runDirected(input string name, input logic [15:0] xv, input logic [5:0] sv,
                              input logic [15:0] ey, input logic eo);
      int cyc;
      cyc = 0;
      applyStimulus(xv, sv);
      while (cyc < 10) begin
         @(negedge clk);
         cyc++;
         if (bus.out_valid === 1'b1) break;
      end
      checkOutput({name, "_latency"}, cyc, 32'd4);
      checkOutput({name, "_y"}, bus.y, ey);
      checkOutput({name, "_ovf"}, bus.ovf, eo);
      @(posedge clk);
      #1;
   endtask

   task automatic waitDrain(input string name);
      int n;
      n = 0;
      while (expQ.size() != 0 && n < 30) begin
         @(posedge clk);
         n++;
      end
      #1;
      checkOutput(name, expQ.size(), 32'd0);
   endtask

   // Monitor: compare every output beat against the model queue, check held
   // outputs during stalls, the ready rule, then account for the next edge.
   always @(negedge clk) begin
      if (prevStall) begin
         checkOutput("stall_hold_valid", bus.out_valid, 32'd1);
         checkOutput("stall_hold_y", bus.y, prevY);
         checkOutput("stall_hold_ovf", bus.ovf, prevOvf);
      end
      if (rstN === 1'b1) begin
         monRdy = bus.out_ready | ~bus.out_valid;
         checkOutput("in_ready_rule", bus.in_ready, monRdy);
      end
      if (bus.out_valid === 1'b1) begin
         if (expQ.size() == 0) begin
            checkOutput("spurious_out_valid", 32'd1, 32'd0);
         end else begin
            monExp = expQ[0];
            checkOutput("model_y", bus.y, monExp[15:0]);
            checkOutput("model_ovf", bus.ovf, monExp[16]);
         end
         if (bus.out_ready !== 1'b1) stallCycles++;
      end
      prevStall = (rstN === 1'b1) && (bus.out_valid === 1'b1) && (bus.out_ready !== 1'b1);
      prevY     = bus.y;
      prevOvf   = bus.ovf;
      if (rstN !== 1'b1) begin
         expQ.delete();
      end else begin
         if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (expQ.size() > 0) void'(expQ.pop_front());
            if (collect) gotQ.push_back(bus.y);
         end
         if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1)
            expQ.push_back(modelBeat(bus.x, bus.sel));
      end
   end

   // Hard time limit so the run always ends.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: time limit reached, passed %0d of %0d", passCount, checkCount);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int outSeen;
      rstN          = 1'b0;
      bus.in_valid  = 1'b0;
      bus.x         = '0;
      bus.sel       = '0;
      bus.out_ready = 1'b1;

      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("reset_out_valid", bus.out_valid, 32'd0);
      checkOutput("reset_y", bus.y, 32'h0000);
      checkOutput("reset_ovf", bus.ovf, 32'd0);
      checkOutput("reset_in_ready", bus.in_ready, 32'd1);
      @(posedge clk);
      #1 rstN = 1'b1;

      runDirected("basic_0003_sl2", 16'h0003, 6'd2,  16'h000C, 1'b0);
      runDirected("ovf_4000_sl1",   16'h4000, 6'd1,  SatEn ? 16'h7FFF : 16'h8000, 1'b1);
      runDirected("sign_C000_sl1",  16'hC000, 6'd1,  16'h8000, 1'b0);
      runDirected("sign_C001_sl2",  16'hC001, 6'd2,  SatEn ? 16'h8000 : 16'h0004, 1'b1);
      runDirected("big_FFFF_sl16",  16'hFFFF, 6'd16, SatEn ? 16'h8000 : 16'h0000, 1'b1);
      runDirected("big_0000_sl63",  16'h0000, 6'd63, 16'h0000, 1'b0);
      runDirected("big_0001_sl15",  16'h0001, 6'd15, SatEn ? 16'h7FFF : 16'h8000, 1'b1);
      runDirected("pass_1234_sl0",  16'h1234, 6'd0,  16'h1234, 1'b0);

      // Back-to-back stream with the output stalled for three cycles.
      gotQ.delete();
      collect     = 1'b1;
      stallCycles = 0;
      fork
         begin
            for (int i = 0; i < 8; i++) applyStimulus(16'(i + 1), 6'd1);
         end
         begin
            repeat (5) @(posedge clk);
            #1 bus.out_ready = 1'b0;
            repeat (3) @(posedge clk);
            #1 bus.out_ready = 1'b1;
         end
      join
      waitDrain("stream_drain");
      collect = 1'b0;
      checkOutput("stream_count", gotQ.size(), 32'd8);
      for (int i = 0; i < 8; i++) begin
         if (i < gotQ.size())
            checkOutput($sformatf("stream_y%0d", i), gotQ[i], 32'(2 * (i + 1)));
      end
      checkOutput("stream_stalled", stallCycles > 0, 32'd1);

      // Reset while three beats are in flight: none of them may come out.
      for (int i = 0; i < 3; i++) applyStimulus(16'h0100 + 16'(i), 6'd4);
      rstN = 1'b0;
      @(posedge clk);
      #1 rstN = 1'b1;
      outSeen = 0;
      repeat (8) begin
         @(negedge clk);
         if (bus.out_valid === 1'b1) outSeen++;
      end
      checkOutput("midreset_no_output", outSeen, 32'd0);
      @(posedge clk);
      #1;
      runDirected("after_reset_0005_sl3", 16'h0005, 6'd3, 16'h0028, 1'b0);

      // Random traffic with random backpressure.
      for (int c = 0; c < 600; c++) begin
         bus.in_valid = ($urandom_range(0, 9) < 7);
         case ($urandom_range(0, 5))
            0:       bus.x = 16'h0000;
            1:       bus.x = 16'hFFFF;
            2:       bus.x = 16'h8000;
            3:       bus.x = 16'h7FFF;
            default: bus.x = 16'($urandom);
         endcase
         bus.sel = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(16, 63))
                                               : 6'($urandom_range(0, 15));
         bus.out_ready = ($urandom_range(0, 9) < 7);
         @(posedge clk);
         #1;
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      waitDrain("random_drain");

      @(posedge clk);
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
